rs_encoder: RTL and testbench



---
 rtl/gf_pkg.sv | 55 +++++
 rtl/gf_const_mult.sv | 18 +
 rtl/rs_encoder.sv | 106 ++++++++++
 tb/tb_rs_encoder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf_pkg.sv
// GF(2^8) arithmetic shared by the RS encoder and decoder chain.
package gf_pkg;
  localparam int unsigned SYMB_WIDTH = 8;
  localparam int unsigned N_LEN      = 255;
  localparam int unsigned ROOTS_NUM  = 16;
  localparam int unsigned K_LEN      = N_LEN - ROOTS_NUM;
  localparam int unsigned FIRST_ROOT = 1;
  localparam logic [SYMB_WIDTH:0] PRIM_POLY = 9'h11d;

  typedef logic [SYMB_WIDTH-1:0] symb_t;
  typedef logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0] gen_poly_t;
  typedef logic [SYMB_WIDTH-1:0][SYMB_WIDTH-1:0] mult_matrix_t;

  // Shift-and-add multiply reduced by the primitive polynomial.
  function automatic symb_t gf_mult(input symb_t a, input symb_t b);
    symb_t acc;
    symb_t sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < int'(SYMB_WIDTH); i++) begin
      if (b[i]) acc ^= sh;
      sh = sh[SYMB_WIDTH-1] ? (symb_t'(sh << 1) ^ PRIM_POLY[SYMB_WIDTH-1:0])
                            : symb_t'(sh << 1);
    end
    return acc;
  endfunction

  function automatic symb_t alpha_to_symb(input int unsigned e);
    symb_t r;
    r = symb_t'(1);
    for (int unsigned i = 0; i < e % N_LEN; i++) r = gf_mult(r, symb_t'(2));
    return r;
  endfunction

  // Builds prod (x + alpha^(FIRST_ROOT+i)); the monic top term is dropped.
  function automatic gen_poly_t gen_gen_poly();
    logic [ROOTS_NUM:0][SYMB_WIDTH-1:0] g;
    symb_t root;
    g    = '0;
    g[0] = symb_t'(1);
    for (int unsigned i = 0; i < ROOTS_NUM; i++) begin
      root = alpha_to_symb(FIRST_ROOT + i);
      for (int j = int'(ROOTS_NUM); j > 0; j--) g[j] = g[j-1] ^ gf_mult(g[j], root);
      g[0] = gf_mult(g[0], root);
    end
    return g[ROOTS_NUM-1:0];
  endfunction

  // Row k holds coef * alpha^k, so a product is the XOR of rows selected by input bits.
  function automatic mult_matrix_t const_matrix(input symb_t coef);
    mult_matrix_t m;
    for (int k = 0; k < int'(SYMB_WIDTH); k++) m[k] = gf_mult(coef, symb_t'(symb_t'(1) << k));
    return m;
  endfunction
endpackage

// File: rtl/gf_const_mult.sv
// Combinational GF multiply by an elaboration-time constant as an XOR matrix.
module gf_const_mult
  import gf_pkg::*;
#(
  parameter symb_t COEF = symb_t'(0)
) (
  input  logic [SYMB_WIDTH-1:0] a,
  output logic [SYMB_WIDTH-1:0] prod_c
);
  localparam mult_matrix_t MATRIX = const_matrix(COEF);

  always_comb begin
    prod_c = '0;
    for (int k = 0; k < int'(SYMB_WIDTH); k++) begin
      if (a[k]) prod_c ^= MATRIX[k];
    end
  end
endmodule

// File: rtl/rs_encoder.sv
// Systematic RS encoder: forwards message symbols, then appends LFSR parity.
module rs_encoder
  import gf_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [SYMB_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [SYMB_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  len_err
);
  localparam gen_poly_t   GEN       = gen_gen_poly();
  localparam int unsigned MSG_CNT_W = $clog2(K_LEN);
  localparam int unsigned PAR_CNT_W = $clog2(ROOTS_NUM);

  typedef enum logic {MSG, PARITY} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [MSG_CNT_W-1:0]    msg_cnt;
  logic [PAR_CNT_W-1:0]    par_cnt;
  gen_poly_t               par;
  gen_poly_t               fb_prod;
  symb_t                   fb;
  logic                    advance;
  logic                    accept;
  logic                    len_hit;
  logic                    msg_end;
  logic                    par_done;

  // Output register may take a new value when empty or being drained.
  assign advance  = !m_valid || m_ready;
  assign s_ready  = (state == MSG) && advance;
  assign accept   = s_valid && s_ready;
  assign fb       = s_data ^ par[ROOTS_NUM-1];
  assign len_hit  = (msg_cnt == MSG_CNT_W'(K_LEN - 1));
  assign msg_end  = s_last || len_hit;
  assign par_done = (par_cnt == PAR_CNT_W'(ROOTS_NUM - 1));

  for (genvar j = 0; j < int'(ROOTS_NUM); j++) begin : g_mult
    gf_const_mult #(.COEF(GEN[j])) u_mult (
      .a      (fb),
      .prod_c (fb_prod[j])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MSG;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      MSG:     if (accept && msg_end) state_next = PARITY;
      PARITY:  if (advance && par_done) state_next = MSG;
      default: state_next = MSG;
    endcase
  end

  // Datapath: parity LFSR, counters and the single output register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par     <= '0;
      msg_cnt <= '0;
      par_cnt <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      len_err <= 1'b0;
    end else begin
      len_err <= 1'b0;
      if (state == MSG) begin
        if (accept) begin
          par[0] <= fb_prod[0];
          for (int j = 1; j < int'(ROOTS_NUM); j++) par[j] <= par[j-1] ^ fb_prod[j];
          m_valid <= 1'b1;
          m_data  <= s_data;
          m_last  <= 1'b0;
          if (msg_end) begin
            msg_cnt <= '0;
            par_cnt <= '0;
            len_err <= !s_last;
          end else begin
            msg_cnt <= msg_cnt + 1'b1;
          end
        end else if (advance) begin
          m_valid <= 1'b0;
          m_last  <= 1'b0;
        end
      end else if (advance) begin
        // Highest-degree parity leaves first; zero fill leaves par clear for the next codeword.
        m_valid <= 1'b1;
        m_data  <= par[ROOTS_NUM-1];
        m_last  <= par_done;
        par     <= {par[ROOTS_NUM-2:0], symb_t'(0)};
        par_cnt <= par_done ? '0 : par_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rs_encoder.sv
// Self-checking bench for rs_encoder: division-based reference model, scoreboard and syndrome check.
module tb_rs_encoder;
  localparam int R = 16;
  localparam int K = 239;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid, s_ready, s_last;
  logic [7:0] s_data;
  logic       m_valid, m_ready, m_last, len_err;
  logic [7:0] m_data;

  always #5 clk = ~clk;

  rs_encoder dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .len_err (len_err)
  );

  int tests = 0;
  int fails = 0;
  int exp_t [0:254];
  int log_t [0:255];
  int gpoly [0:R];
  logic [7:0] msg [0:K-1];

  typedef struct {
    logic [7:0] data;
    bit         last;
    bit         busy;
    bit         lerr;
    int         cnt;
    int         nlerr;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    int len;
    bit use_last;
    int kind;
    bit stall;
    bit exp_lerr;
  } vec_t;
  vec_t vecs [0:6];

  bit stall_mode = 1'b0;
  bit sb_off     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return exp_t[(log_t[a] + log_t[b]) % 255];
  endfunction

  task automatic build_tables();
    int x;
    x = 1;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = x;
      log_t[x] = i;
      x = x << 1;
      if ((x & 256) != 0) x = x ^ 285;
    end
    for (int j = 0; j <= R; j++) gpoly[j] = 0;
    gpoly[0] = 1;
    for (int i = 0; i < R; i++) begin
      int r;
      r = exp_t[(1 + i) % 255];
      for (int j = R; j > 0; j--) gpoly[j] = gpoly[j-1] ^ gmul(gpoly[j], r);
      gpoly[0] = gmul(gpoly[0], r);
    end
  endtask

  // Remainder of m(x)*x^16 by long division, pushed after the message symbols.
  task automatic push_cw(input int len, input bit lerr);
    int  c [0:K+R-1];
    sb_t e;
    for (int i = 0; i < len; i++) c[i] = msg[i];
    for (int i = 0; i < R; i++) c[len+i] = 0;
    for (int i = 0; i < len; i++) begin
      int coef;
      coef = c[i];
      if (coef != 0)
        for (int k = 0; k < R; k++) c[i+R-k] = c[i+R-k] ^ gmul(coef, gpoly[k]);
    end
    for (int i = 0; i < len; i++) begin
      e.data = msg[i]; e.last = 1'b0; e.busy = (i == len - 1);
      e.lerr = lerr && (i == len - 1); e.cnt = len + R; e.nlerr = int'(lerr);
      sbq.push_back(e);
    end
    for (int p = 0; p < R; p++) begin
      e.data = 8'(c[len+p]); e.last = (p == R - 1); e.busy = (p != R - 1);
      e.lerr = 1'b0; e.cnt = len + R; e.nlerr = int'(lerr);
      sbq.push_back(e);
    end
  endtask

  int         cw_cnt = 0;
  int         pulses = 0;
  bit         hold_v = 1'b0;
  bit         prev_v = 1'b0;
  logic [7:0] hold_d;
  logic       hold_l;
  int         rx[$];

  function automatic bit syn_nonzero();
    for (int i = 0; i < R; i++) begin
      int r, s;
      r = exp_t[(1 + i) % 255];
      s = 0;
      foreach (rx[k]) s = gmul(s, r) ^ rx[k];
      if (s != 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Output monitor: sampled mid-cycle, popping the scoreboard on each transfer.
  always @(negedge clk) begin
    sb_t e;
    if (sb_off || rst) begin
      cw_cnt = 0; pulses = 0; hold_v = 1'b0; prev_v = 1'b0; rx.delete();
    end else begin
      if (hold_v) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, hold_d);
        check("hold_last", m_last, hold_l);
      end
      hold_v = 1'b0;
      if (!stall_mode && prev_v && sbq.size() > 0) check("bubble", m_valid, 1);
      prev_v = m_valid;
      if (len_err) begin
        pulses++;
        check("len_err_pos", 32'(sbq.size() > 0 && sbq[0].lerr && m_valid), 1);
      end
      if (m_valid) begin
        if (sbq.size() == 0) check("unexpected_out", m_valid, 0);
        else begin
          if (sbq[0].busy) check("s_ready_busy", s_ready, 0);
          if (m_ready) begin
            e = sbq.pop_front();
            check("data", m_data, e.data);
            check("last", m_last, e.last);
            cw_cnt++;
            rx.push_back(int'(m_data));
            if (e.last) begin
              check("cw_len", cw_cnt, e.cnt);
              check("len_err_cnt", pulses, e.nlerr);
              check("syndrome", syn_nonzero(), 0);
              cw_cnt = 0; pulses = 0; rx.delete();
            end
          end else begin
            hold_v = 1'b1; hold_d = m_data; hold_l = m_last;
          end
        end
      end
    end
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_ready = stall_mode ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  end

  task automatic drive_sym(input logic [7:0] d, input bit last, input bit gaps);
    int budget;
    if (gaps) begin
      while ($urandom_range(1, 0) == 1) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    s_valid = 1'b1; s_data = d; s_last = last;
    budget = 0;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      budget++;
      if (budget > 1000) begin
        check("s_ready_timeout", s_ready, 1);
        break;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_empty();
    int budget;
    budget = 0;
    while (sbq.size() > 0 && budget < 5000) begin
      @(posedge clk); #1;
      budget++;
    end
    check("drain", sbq.size(), 0);
  endtask

  initial begin
    build_tables();
    vecs[0] = '{239, 1'b1, 0, 1'b0, 1'b0};
    vecs[1] = '{1,   1'b1, 1, 1'b0, 1'b0};
    vecs[2] = '{239, 1'b1, 2, 1'b0, 1'b0};
    vecs[3] = '{239, 1'b1, 3, 1'b1, 1'b0};
    vecs[4] = '{239, 1'b0, 2, 1'b0, 1'b1};
    vecs[5] = '{5,   1'b1, 2, 1'b0, 1'b0};
    vecs[6] = '{20,  1'b1, 2, 1'b1, 1'b0};

    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_len_err", len_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("s_ready_after_reset", s_ready, 1);
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) begin
      case (vecs[v].kind)
        0: for (int i = 0; i < vecs[v].len; i++) msg[i] = 8'h00;
        1: msg[0] = 8'h01;
        2: for (int i = 0; i < vecs[v].len; i++) msg[i] = 8'($urandom_range(255, 0));
        default: ;
      endcase
      stall_mode = vecs[v].stall;
      push_cw(vecs[v].len, vecs[v].exp_lerr);
      for (int i = 0; i < vecs[v].len; i++)
        drive_sym(msg[i], vecs[v].use_last && (i == vecs[v].len - 1), vecs[v].stall);
    end
    wait_empty();

    // Reset during parity beat 5 of a single-symbol codeword, then rerun it.
    stall_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb_off = 1'b1;
    drive_sym(8'h01, 1'b1, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check("beat5_data", m_data, gpoly[10]);
    rst = 1'b1;
    @(negedge clk);
    check("abort_m_valid", m_valid, 0);
    check("abort_m_last", m_last, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.delete();
    @(negedge clk);
    check("s_ready_after_abort", s_ready, 1);
    @(posedge clk); #1;
    sb_off = 1'b0;
    msg[0] = 8'h01;
    push_cw(1, 1'b0);
    drive_sym(8'h01, 1'b1, 1'b0);
    wait_empty();
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
